// File: rtl/types_def_pkg.sv
// Shared transaction types for the front-end request path.
// Ports carry widths as separate fields, so only the request kind lives here.
package types_def;

  typedef enum logic {
    R_READ  = 1'b0,
    R_WRITE = 1'b1
  } r_type;

endpackage

// File: rtl/txn_ring.sv
// In-order allocation ring: hands out indices at the tail, collects out-of-order
// completions, and retires the head entry once its completion has arrived.
module txn_ring #(
  parameter int DEPTH      = 64,
  parameter int DATA_W     = 32,
  parameter bit STORE_DATA = 1'b1,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc,
  output logic [IDX_W-1:0]  alloc_index,
  output logic              full,
  input  logic              done_valid,
  input  logic [IDX_W-1:0]  done_index,
  input  logic [DATA_W-1:0] done_data,
  output logic              retire_valid,
  output logic [IDX_W-1:0]  retire_index,
  output logic [DATA_W-1:0] retire_data
);

  localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(DEPTH);

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W:0]   count;
  logic [DEPTH-1:0] done_bits;
  logic [IDX_W-1:0] offset;
  logic             done_ok;
  logic             head_hit;

  // An entry is allocated when its distance from head is below count;
  // completions for free or already-done entries are dropped here.
  always_comb begin
    offset       = done_index - head;
    done_ok      = done_valid && ({1'b0, offset} < count) && !done_bits[done_index];
    head_hit     = done_ok && (done_index == head);
    retire_valid = done_bits[head] || head_hit;
    full         = (count == FULL_COUNT) && !retire_valid;
  end

  assign alloc_index  = tail;
  assign retire_index = head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      done_bits <= '0;
    end else begin
      if (alloc) begin
        tail <= tail + 1'b1;
      end
      if (retire_valid) begin
        head <= head + 1'b1;
      end
      if (alloc && !retire_valid) begin
        count <= count + 1'b1;
      end else if (!alloc && retire_valid) begin
        count <= count - 1'b1;
      end
      if (done_ok) begin
        done_bits[done_index] <= 1'b1;
      end
      // Retire clears the head bit last so a same-cycle head completion never sticks.
      if (retire_valid) begin
        done_bits[head] <= 1'b0;
      end
    end
  end

  generate
    if (STORE_DATA) begin : g_data
      logic [DATA_W-1:0] mem [DEPTH];

      always_ff @(posedge clk) begin
        if (done_ok) begin
          mem[done_index] <= done_data;
        end
      end

      assign retire_data = head_hit ? done_data : mem[head];
    end else begin : g_no_data
      logic unused_data;
      assign unused_data = ^done_data;
      assign retire_data = '0;
    end
  endgenerate

endmodule

// File: rtl/txn_dispatcher.sv
// Front-end transaction dispatcher: tags requests from per-type rings, routes them
// to one bank through a one-entry output slot, buffers write data, and returns reads in order.
module txn_dispatcher
  import types_def::*;
#(
  parameter int NUM_BANKS = 16,
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BANK_LSB  = 2,
  localparam int BANK_W   = $clog2(NUM_BANKS),
  localparam int IDX_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  r_type                in_type,
  input  logic [ADDR_W-1:0]    in_addr,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 out_busy,
  output logic [NUM_BANKS-1:0] out_valid,
  output r_type                out_type,
  output logic [ADDR_W-1:0]    out_addr,
  output logic [IDX_W-1:0]     out_index,
  input  logic [NUM_BANKS-1:0] grant_i,
  input  logic                 wd_req,
  input  logic [IDX_W-1:0]     wd_index,
  output logic [DATA_W-1:0]    wd_data,
  input  logic                 done_valid,
  input  r_type                done_type,
  input  logic [IDX_W-1:0]     done_index,
  input  logic [DATA_W-1:0]    done_data,
  output logic                 rd_valid,
  output logic [IDX_W-1:0]     rd_index,
  output logic [DATA_W-1:0]    rd_data
);

  logic              accept;
  logic              grant_hit;
  logic              ring_full;
  logic              r_alloc;
  logic              w_alloc;
  logic              r_done;
  logic              w_done;
  logic              r_full;
  logic              w_full;
  logic [IDX_W-1:0]  r_tail;
  logic [IDX_W-1:0]  w_tail;
  logic [IDX_W-1:0]  alloc_index;
  logic [BANK_W-1:0] bank_sel;
  logic              r_retire;
  logic [IDX_W-1:0]  r_retire_index;
  logic [DATA_W-1:0] r_retire_data;
  logic              w_retire_unused;
  logic [IDX_W-1:0]  w_retire_index_unused;
  logic [DATA_W-1:0] w_retire_data_unused;
  logic [DATA_W-1:0] wbuf [DEPTH];

  // Handshake: a request is taken when in_valid is high and out_busy is low in the
  // same cycle; the slot hands its request to a bank when grant_i overlaps out_valid.
  always_comb begin
    grant_hit   = |(grant_i & out_valid);
    ring_full   = (in_type == R_WRITE) ? w_full : r_full;
    out_busy    = ((|out_valid) && !grant_hit) || ring_full;
    accept      = in_valid && !out_busy;
    r_alloc     = accept && (in_type == R_READ);
    w_alloc     = accept && (in_type == R_WRITE);
    r_done      = done_valid && (done_type == R_READ);
    w_done      = done_valid && (done_type == R_WRITE);
    alloc_index = (in_type == R_WRITE) ? w_tail : r_tail;
    bank_sel    = in_addr[BANK_LSB +: BANK_W];
  end

  txn_ring #(
    .DEPTH      (DEPTH),
    .DATA_W     (DATA_W),
    .STORE_DATA (1'b1)
  ) u_read_ring (
    .clk          (clk),
    .rst          (rst),
    .alloc        (r_alloc),
    .alloc_index  (r_tail),
    .full         (r_full),
    .done_valid   (r_done),
    .done_index   (done_index),
    .done_data    (done_data),
    .retire_valid (r_retire),
    .retire_index (r_retire_index),
    .retire_data  (r_retire_data)
  );

  txn_ring #(
    .DEPTH      (DEPTH),
    .DATA_W     (DATA_W),
    .STORE_DATA (1'b0)
  ) u_write_ring (
    .clk          (clk),
    .rst          (rst),
    .alloc        (w_alloc),
    .alloc_index  (w_tail),
    .full         (w_full),
    .done_valid   (w_done),
    .done_index   (done_index),
    .done_data    (done_data),
    .retire_valid (w_retire_unused),
    .retire_index (w_retire_index_unused),
    .retire_data  (w_retire_data_unused)
  );

  // A grant and a new accept on the same edge simply reload the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      out_type  <= R_READ;
      out_addr  <= '0;
      out_index <= '0;
    end else if (accept) begin
      out_valid <= NUM_BANKS'(1) << bank_sel;
      out_type  <= in_type;
      out_addr  <= in_addr;
      out_index <= alloc_index;
    end else if (grant_hit) begin
      out_valid <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        wbuf[i] <= '0;
      end
    end else if (w_alloc) begin
      wbuf[w_tail] <= in_data;
    end
  end

  // Fetches ignore ring state; a fetch of the slot being written this cycle sees old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_data <= '0;
    end else if (wd_req) begin
      wd_data <= wbuf[wd_index];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_index <= '0;
      rd_data  <= '0;
    end else begin
      rd_valid <= r_retire;
      if (r_retire) begin
        rd_index <= r_retire_index;
        rd_data  <= r_retire_data;
      end
    end
  end

endmodule

// File: tb/tb_txn_dispatcher.sv
// Scoreboard bench for txn_dispatcher: a queue-based reference model predicts
// dispatches, in-order read returns and write-data fetches; a monitor pops and compares.
module tb_txn_dispatcher;
  import types_def::*;

  localparam int NUM_BANKS = 16;
  localparam int DEPTH     = 64;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int BANK_LSB  = 2;
  localparam int IDX_W     = 6;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  r_type                in_type;
  logic [ADDR_W-1:0]    in_addr;
  logic [DATA_W-1:0]    in_data;
  logic                 out_busy;
  logic [NUM_BANKS-1:0] out_valid;
  r_type                out_type;
  logic [ADDR_W-1:0]    out_addr;
  logic [IDX_W-1:0]     out_index;
  logic [NUM_BANKS-1:0] grant_i;
  logic                 wd_req;
  logic [IDX_W-1:0]     wd_index;
  logic [DATA_W-1:0]    wd_data;
  logic                 done_valid;
  r_type                done_type;
  logic [IDX_W-1:0]     done_index;
  logic [DATA_W-1:0]    done_data;
  logic                 rd_valid;
  logic [IDX_W-1:0]     rd_index;
  logic [DATA_W-1:0]    rd_data;

  txn_dispatcher #(
    .NUM_BANKS (NUM_BANKS),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .BANK_LSB  (BANK_LSB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_type    (in_type),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .out_busy   (out_busy),
    .out_valid  (out_valid),
    .out_type   (out_type),
    .out_addr   (out_addr),
    .out_index  (out_index),
    .grant_i    (grant_i),
    .wd_req     (wd_req),
    .wd_index   (wd_index),
    .wd_data    (wd_data),
    .done_valid (done_valid),
    .done_type  (done_type),
    .done_index (done_index),
    .done_data  (done_data),
    .rd_valid   (rd_valid),
    .rd_index   (rd_index),
    .rd_data    (rd_data)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard queues ----------------
  typedef struct packed {
    r_type                typ;
    logic [ADDR_W-1:0]    addr;
    logic [IDX_W-1:0]     idx;
    logic [NUM_BANKS-1:0] bank;
  } disp_t;

  typedef struct packed {
    logic [31:0]       cyc;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } rd_t;

  typedef struct packed {
    logic [31:0]       cyc;
    logic [DATA_W-1:0] data;
  } wd_t;

  disp_t disp_q[$];
  rd_t   rd_q[$];
  wd_t   wd_q[$];

  // ---------------- reference model ----------------
  // Each ring is a queue of outstanding indices in allocation order.
  int                rd_ring[$];
  int                wr_ring[$];
  bit                done_m[2][DEPTH];
  int                tail_m[2];
  logic [DATA_W-1:0] rdata_m[DEPTH];
  logic [DATA_W-1:0] wbuf_m[DEPTH];
  bit                slot_v;
  disp_t             slot_m;

  function automatic bit outstanding(input int t, input int idx);
    bit found = 0;
    if (t == 0) begin
      foreach (rd_ring[i]) if (rd_ring[i] == idx) found = 1;
    end else begin
      foreach (wr_ring[i]) if (wr_ring[i] == idx) found = 1;
    end
    return found;
  endfunction

  always @(negedge clk) begin : model
    int  idx;
    int  t;
    bit  hit;
    bit  busy_e;
    bit  full_e;
    rd_t re;
    wd_t we;
    if (rst) begin
      rd_ring.delete();
      wr_ring.delete();
      disp_q.delete();
      rd_q.delete();
      wd_q.delete();
      tail_m[0] = 0;
      tail_m[1] = 0;
      slot_v = 0;
      for (int i = 0; i < DEPTH; i++) begin
        done_m[0][i] = 0;
        done_m[1][i] = 0;
        wbuf_m[i]    = '0;
      end
    end else begin
      chk("slot_bank", 64'(out_valid), slot_v ? 64'(slot_m.bank) : 64'd0);
      if (slot_v) begin
        chk("slot_type", 64'(out_type), 64'(slot_m.typ));
        chk("slot_addr", 64'(out_addr), 64'(slot_m.addr));
        chk("slot_index", 64'(out_index), 64'(slot_m.idx));
      end
      if (done_valid) begin
        t = (done_type == R_WRITE) ? 1 : 0;
        if (outstanding(t, int'(done_index)) && !done_m[t][done_index]) begin
          done_m[t][done_index] = 1;
          if (t == 0) rdata_m[done_index] = done_data;
        end
      end
      if (rd_ring.size() > 0 && done_m[0][rd_ring[0]]) begin
        idx = rd_ring.pop_front();
        done_m[0][idx] = 0;
        re.cyc  = 32'(cyc + 1);
        re.idx  = IDX_W'(idx);
        re.data = rdata_m[idx];
        rd_q.push_back(re);
      end
      if (wr_ring.size() > 0 && done_m[1][wr_ring[0]]) begin
        idx = wr_ring.pop_front();
        done_m[1][idx] = 0;
      end
      full_e = (in_type == R_WRITE) ? (wr_ring.size() == DEPTH) : (rd_ring.size() == DEPTH);
      hit    = slot_v && ((grant_i & slot_m.bank) != '0);
      busy_e = (slot_v && !hit) || full_e;
      chk("out_busy", 64'(out_busy), 64'(busy_e));
      if (wd_req) begin
        we.cyc  = 32'(cyc + 1);
        we.data = wbuf_m[wd_index];
        wd_q.push_back(we);
      end
      if (in_valid && !busy_e) begin
        t = (in_type == R_WRITE) ? 1 : 0;
        idx = tail_m[t];
        tail_m[t] = (idx + 1) % DEPTH;
        if (t == 0) rd_ring.push_back(idx);
        else begin
          wr_ring.push_back(idx);
          wbuf_m[idx] = in_data;
        end
        slot_m.typ  = in_type;
        slot_m.addr = in_addr;
        slot_m.idx  = IDX_W'(idx);
        slot_m.bank = NUM_BANKS'(1) << ((in_addr >> BANK_LSB) % NUM_BANKS);
        slot_v = 1;
        disp_q.push_back(slot_m);
      end else if (hit) begin
        slot_v = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    disp_t de;
    rd_t   re;
    wd_t   we;
    if (!rst) begin
      if ((out_valid & grant_i) != '0) begin
        if (disp_q.size() == 0) begin
          chk("dispatch_unexpected", 64'(out_valid), 64'd0);
        end else begin
          de = disp_q.pop_front();
          chk("dispatch", 64'({out_type, out_addr, out_index, out_valid}), 64'(de));
        end
      end
      if (rd_valid) begin
        if (rd_q.size() == 0) begin
          chk("rd_unexpected", 64'(rd_valid), 64'd0);
        end else begin
          re = rd_q.pop_front();
          chk("rd_cycle", 64'(cyc), 64'(re.cyc));
          chk("rd_index", 64'(rd_index), 64'(re.idx));
          chk("rd_data", 64'(rd_data), 64'(re.data));
        end
      end else if (rd_q.size() > 0 && int'(rd_q[0].cyc) <= cyc) begin
        re = rd_q.pop_front();
        chk("rd_missing", 64'(rd_valid), 64'd1);
      end
      if (wd_q.size() > 0 && int'(wd_q[0].cyc) <= cyc) begin
        we = wd_q.pop_front();
        chk("wd_data", 64'(wd_data), 64'(we.data));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input r_type t, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_type  = t;
    in_addr  = a;
    in_data  = d;
  endtask

  task automatic drive_done(input r_type t, input int idx, input logic [DATA_W-1:0] d);
    done_valid = 1'b1;
    done_type  = t;
    done_index = IDX_W'(idx);
    done_data  = d;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    done_valid = 1'b0;
    wd_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_type", 64'(out_type), 64'(R_READ));
    chk("rst_out_addr", 64'(out_addr), 64'd0);
    chk("rst_out_index", 64'(out_index), 64'd0);
    chk("rst_wd_data", 64'(wd_data), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_index", 64'(rd_index), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_out_busy", 64'(out_busy), 64'd0);
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic drain();
    int guard = 0;
    int ct[$];
    int ci[$];
    int k;
    in_valid = 1'b0;
    while ((rd_ring.size() + wr_ring.size()) > 0 && guard < 600) begin
      ct.delete();
      ci.delete();
      foreach (rd_ring[i]) if (!done_m[0][rd_ring[i]]) begin ct.push_back(0); ci.push_back(rd_ring[i]); end
      foreach (wr_ring[i]) if (!done_m[1][wr_ring[i]]) begin ct.push_back(1); ci.push_back(wr_ring[i]); end
      if (ct.size() > 0) begin
        k = $urandom_range(0, ct.size() - 1);
        drive_done(ct[k] ? R_WRITE : R_READ, ci[k], $urandom);
      end else begin
        done_valid = 1'b0;
      end
      tick();
      guard++;
    end
    done_valid = 1'b0;
    checks++;
    if (guard >= 600) begin
      errors++;
      $display("FAIL drain_timeout: %0d entries still outstanding, required 0", rd_ring.size() + wr_ring.size());
    end
    repeat (3) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_type = R_READ;
    in_addr = '0;
    in_data = '0;
    grant_i = '0;
    wd_req = 1'b0;
    wd_index = '0;
    done_valid = 1'b0;
    done_type = R_READ;
    done_index = '0;
    done_data = '0;
    repeat (3) tick();
    do_reset();

    // Fill the read ring back-to-back on bank 0.
    grant_i = '1;
    for (int i = 0; i < DEPTH; i++) begin
      drive_req(R_READ, 32'h0, $urandom);
      tick();
    end
    drive_req(R_READ, 32'h0, 32'h0);
    @(negedge clk);
    chk("busy_read_ring_full", 64'(out_busy), 64'd1);
    tick();
    drive_req(R_WRITE, 32'h4, 32'hAA);
    @(negedge clk);
    chk("write_while_reads_full", 64'(out_busy), 64'd0);
    tick();

    // Retire head and allocate a read in the same cycle.
    drive_req(R_READ, 32'h8, 32'h0);
    drive_done(R_READ, 0, 32'h1234);
    @(negedge clk);
    chk("retire_alloc_same_cycle", 64'(out_busy), 64'd0);
    tick();
    done_valid = 1'b0;
    drive_req(R_WRITE, 32'hC, 32'h77);
    @(negedge clk);
    chk("write_no_busy_glitch", 64'(out_busy), 64'd0);
    tick();
    drive_req(R_READ, 32'h10, 32'h0);
    @(negedge clk);
    chk("read_ring_still_full", 64'(out_busy), 64'd1);
    tick();
    drain();

    // Stall with grant low, then resume.
    grant_i = '0;
    drive_req(R_READ, 32'h20, 32'h0);
    tick();
    drive_req(R_WRITE, 32'h24, 32'h55);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_busy", 64'(out_busy), 64'd1);
      chk("stall_slot_hold", 64'(out_addr), 64'h20);
      tick();
    end
    grant_i = '1;
    @(negedge clk);
    chk("resume_busy", 64'(out_busy), 64'd0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("resume_slot_addr", 64'(out_addr), 64'h24);
    tick();
    drain();

    // Out-of-order completion, in-order return.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_req(R_READ, 32'(i * 4), 32'h0);
      tick();
    end
    in_valid = 1'b0;
    drive_done(R_READ, 2, 32'hC);
    tick();
    drive_done(R_READ, 1, 32'hB);
    tick();
    drive_done(R_READ, 0, 32'hA);
    tick();
    done_valid = 1'b0;
    @(negedge clk);
    chk("ooo_ret0", 64'({rd_valid, rd_index, rd_data}), {25'd0, 1'b1, 6'd0, 32'hA});
    tick();
    @(negedge clk);
    chk("ooo_ret1", 64'({rd_valid, rd_index, rd_data}), {25'd0, 1'b1, 6'd1, 32'hB});
    tick();
    @(negedge clk);
    chk("ooo_ret2", 64'({rd_valid, rd_index, rd_data}), {25'd0, 1'b1, 6'd2, 32'hC});
    tick();

    // Write data buffered by index.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive_req(R_WRITE, 32'(i * 4), (i == 5) ? 32'd10 : 32'(32'h100 + i));
      tick();
    end
    in_valid = 1'b0;
    wd_req = 1'b1;
    wd_index = 6'd5;
    tick();
    wd_req = 1'b0;
    @(negedge clk);
    chk("wd_fetch_idx5", 64'(wd_data), 64'd10);
    tick();
    drain();

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      int k;
      in_valid = 1'($urandom_range(0, 1));
      in_type  = ($urandom_range(0, 1) != 0) ? R_WRITE : R_READ;
      in_addr  = $urandom;
      in_data  = $urandom;
      grant_i  = ($urandom_range(0, 3) == 0) ? '0 : NUM_BANKS'($urandom);
      wd_req   = 1'($urandom_range(0, 1));
      wd_index = IDX_W'($urandom_range(0, DEPTH - 1));
      k = $urandom_range(0, 3);
      if (k == 0) begin
        done_valid = 1'b0;
      end else if (k == 1 || (rd_ring.size() + wr_ring.size()) == 0) begin
        drive_done(($urandom_range(0, 1) != 0) ? R_WRITE : R_READ, $urandom_range(0, DEPTH - 1), $urandom);
      end else if (rd_ring.size() > 0 && (wr_ring.size() == 0 || $urandom_range(0, 1) == 0)) begin
        drive_done(R_READ, rd_ring[$urandom_range(0, rd_ring.size() - 1)], $urandom);
      end else begin
        drive_done(R_WRITE, wr_ring[$urandom_range(0, wr_ring.size() - 1)], $urandom);
      end
      tick();
    end
    wd_req = 1'b0;
    grant_i = '1;
    drain();

    // Reset with entries outstanding; late completions must be ignored.
    for (int i = 0; i < 10; i++) begin
      drive_req(R_READ, 32'(i * 4), 32'h0);
      tick();
    end
    in_valid = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive_done(R_READ, i, 32'(32'hD0 + i));
      tick();
      @(negedge clk);
      chk("rd_after_reset", 64'(rd_valid), 64'd0);
    end
    done_valid = 1'b0;
    repeat (5) tick();

    chk("dispatch_queue_empty", 64'(disp_q.size()), 64'd0);
    chk("read_queue_empty", 64'(rd_q.size()), 64'd0);
    chk("wd_queue_empty", 64'(wd_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
